// File: rtl/fifos_salida_pkg.sv
// fifos_salida_pkg
//   Shared constants and helpers for the output FIFO bank.
//   N_FIFOS        : number of FIFOs in the bank
//   DEST_W         : width of the destination field at the top of each word
//   DATA_W_DEF     : default word width
//   DEPTH_DEF      : default entries per FIFO
//   ptr_w(depth)   : read/write pointer width for a FIFO of the given depth
package fifos_salida_pkg;

   localparam int N_FIFOS    = 4;
   localparam int DEST_W     = 2;
   localparam int DATA_W_DEF = 6;
   localparam int DEPTH_DEF  = 4;

   // Pointer width is log2(depth); a depth below 2 still gets one bit.
   function automatic int ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fifos_salida_fifo_simple.sv
// fifo_simple
//   One synchronous FIFO with a registered read port (latency 1).
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     push_i       : write request; accepted when not full or popped same cycle
//     pop_i        : read request; accepted only when not empty
//     data_i       : write data
//     data_o       : registered read data, holds its value between pops
//     valid_o      : high for one cycle when data_o holds a freshly popped word
//     pop_ok_o     : combinational accepted-pop strobe
//     overflow_o   : push dropped because the FIFO is full and not popping
//     count_o      : registered occupancy, 0..DEPTH
//     empty_o      : count == 0
//     full_o       : count == DEPTH
module fifo_simple
   import fifos_salida_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   localparam int PW    = ptr_w(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              pop_ok_o,
   output logic              overflow_o,
   output logic [CW-1:0]     count_o,
   output logic              empty_o,
   output logic              full_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              push_ok;

   assign empty_o  = (cnt_q == '0);
   assign full_o   = (cnt_q == CW'(DEPTH));
   assign count_o  = cnt_q;
   assign data_o   = data_q;
   assign valid_o  = valid_q;

   // No fall-through: a pop needs a word already stored before this edge.
   assign pop_ok_o   = pop_i & ~empty_o;
   // A full FIFO still takes a push when the same cycle frees a slot.
   assign push_ok    = push_i & (~full_o | pop_ok_o);
   assign overflow_o = push_i & full_o & ~pop_ok_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      if (push_ok) begin
         // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_ok_o) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         data_d   = mem_q[rd_ptr_q];
         valid_d  = 1'b1;
      end
      case ({push_ok, pop_ok_o})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   // Storage carries no reset; its contents are meaningless while count is 0.
   // On a full push+pop the write lands on the slot being read; the read
   // above samples the old word because mem_q updates only after the edge.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/fifos_salida.sv
// fifos_salida
//   Output FIFO bank: four independent FIFOs behind one routed write port.
//   The destination FIFO is data_in[DATA_W-1:DATA_W-2]; the whole word,
//   destination bits included, is stored.
//   Optional build macro: FIFOS_SALIDA_PAUSE_EN adds a registered pause output.
//   Ports:
//     clk, rst                   : clock, asynchronous active-high reset
//     push, data_in              : routed write port
//     pop[3:0]                   : per-FIFO read request
//     data_out_0..data_out_3     : registered read data per FIFO
//     valid_out[3:0]             : read data valid strobes
//     pop_ok[3:0]                : accepted pops, combinational
//     empty/full[3:0]            : occupancy flags
//     almost_empty/almost_full   : threshold flags (count <= AE_TH, >= AF_TH)
//     error                      : sticky overflow flag
//     pause (optional)           : high while any FIFO was almost full last cycle
//
// Read handshake: pop[i] is a request, not a held valid. It is accepted in a
// cycle only when FIFO i is not empty (pop_ok[i]=1); an accepted pop at edge N
// shows the head word on data_out_i with valid_out[i]=1 for exactly the cycle
// after edge N. A refused pop has no effect and produces no valid.
module fifos_salida
   import fifos_salida_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int AF_TH  = 3,
   parameter int AE_TH  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic [3:0]        pop,
   output logic [DATA_W-1:0] data_out_0,
   output logic [DATA_W-1:0] data_out_1,
   output logic [DATA_W-1:0] data_out_2,
   output logic [DATA_W-1:0] data_out_3,
   output logic [3:0]        valid_out,
   output logic [3:0]        pop_ok,
   output logic [3:0]        empty,
   output logic [3:0]        full,
   output logic [3:0]        almost_empty,
   output logic [3:0]        almost_full,
   output logic              error
`ifdef FIFOS_SALIDA_PAUSE_EN
   ,
   output logic              pause
`endif
);

   localparam int CW = ptr_w(DEPTH) + 1;

   logic [DEST_W-1:0] dest;
   logic [3:0]        push_vec;
   logic [3:0]        ovf;
   logic [DATA_W-1:0] dout [N_FIFOS];
   logic [CW-1:0]     cnt  [N_FIFOS];
   logic              error_q, error_d;

   assign dest = data_in[DATA_W-1 -: DEST_W];

   for (genvar g = 0; g < N_FIFOS; g++) begin : g_fifo
      // Exactly one FIFO sees the push, selected by the destination field.
      assign push_vec[g] = push & (dest == DEST_W'(g));

      fifo_simple #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .push_i     (push_vec[g]),
         .pop_i      (pop[g]),
         .data_i     (data_in),
         .data_o     (dout[g]),
         .valid_o    (valid_out[g]),
         .pop_ok_o   (pop_ok[g]),
         .overflow_o (ovf[g]),
         .count_o    (cnt[g]),
         .empty_o    (empty[g]),
         .full_o     (full[g])
      );

      assign almost_empty[g] = (cnt[g] <= CW'(AE_TH));
      assign almost_full[g]  = (cnt[g] >= CW'(AF_TH));
   end

   assign data_out_0 = dout[0];
   assign data_out_1 = dout[1];
   assign data_out_2 = dout[2];
   assign data_out_3 = dout[3];

   // Overflow is sticky: once a word is dropped only reset clears the flag.
   assign error_d = error_q | (|ovf);
   assign error   = error_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

`ifdef FIFOS_SALIDA_PAUSE_EN
   logic pause_q, pause_d;

   // Registered, so pause trails almost_full by one cycle in both directions.
   assign pause_d = |almost_full;
   assign pause   = pause_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pause_q <= 1'b0;
      end else begin
         pause_q <= pause_d;
      end
   end
`endif

endmodule

// File: doc/fifos_salida.md
Name: fifos_salida

Overview:
- Output FIFO bank: four independent FIFOs fed by a single routed write port; destination comes from the top bits of the word.
- Sits directly upstream of the output-word counters. Its qualified pop strobes pop_ok[3:0] drive the counters' pop_0..pop_3, and its empty flags feed the FSM's IDLE decision.
- The prober reads each FIFO through a pop/valid handshake.

Parameters:
- DATA_W, 6: word width; bits [DATA_W-1:DATA_W-2] are the destination index.
- DEPTH, 4: entries per FIFO; must be a power of 2, ≥2.
- AF_TH, 3: almost_full asserts when count ≥ AF_TH.
- AE_TH, 1: almost_empty asserts when count ≤ AE_TH.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- push  in  1  write strobe for data_in
- data_in  in  DATA_W  word; top 2 bits select FIFO 0..3
- pop  in  4  per-FIFO read request from prober
- data_out_0..data_out_3  out  DATA_W each  registered read data
- valid_out  out  4  bit i high for one cycle when data_out_i holds a popped word
- pop_ok  out  4  bit i = pop[i] & ~empty[i], combinational; to counters
- empty  out  4  count==0 per FIFO
- full  out  4  count==DEPTH per FIFO
- almost_empty  out  4  count ≤ AE_TH
- almost_full  out  4  count ≥ AF_TH
- error  out  1  sticky overflow flag

Behaviour:
- Reset (async, any cycle, including mid-transfer): all counts, pointers, data_out_*, valid_out and error go to 0. empty=4'hF, almost_empty=4'hF, full=0, almost_full=0. Storage contents are don't-care.
- Write routing: on push, FIFO d = data_in[DATA_W-1:DATA_W-2] receives the full word, destination bits included. Only one FIFO is written per cycle.
- Push to a full FIFO with no same-cycle pop on it: word dropped, count unchanged, error ← 1 (sticky until reset).
- Push and pop on the same full FIFO: both accepted, count unchanged, no error.
- Pop on an empty FIFO: ignored. pop_ok[i]=0, valid_out[i]=0 next cycle, no error. There is no fall-through: push and pop on an empty FIFO accepts the push only.
- Read latency 1: an accepted pop at edge N drives data_out_i with the head word and sets valid_out[i]=1 after edge N. If no pop is accepted, valid_out[i]=0 and data_out_i holds its last value.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits. Count is ±1 per cycle, or unchanged on simultaneous accepted push and pop.
- Flags: empty, full, almost_* are decoded combinationally from the registered count and reflect state after the last edge.
- All four FIFOs pop independently in the same cycle. pop_ok bits may all be 1 together.

Optional Feature:
- FIFOS_SALIDA_PAUSE_EN
- Defined: adds output pause (1 bit), registered. pause=1 the cycle after any almost_full bit is 1; it clears the cycle after all almost_full bits are 0. Upstream must hold push while pause=1; error still applies if it does not.
- Undefined: no pause port, no related logic.

Decomposition:
- Shared package: N_FIFOS=4, DEST_W=2, default DATA_W and DEPTH, and a function for log2 pointer width.
- Sub-module fifo_simple: one synchronous FIFO with push, pop, data, count and flags, instantiated ×4 via generate.
- Top level holds: destination decode, error register, pop_ok gating, optional pause.

Test Plan:
- Reset then push 6'b01_0101 → empty=4'b1101, almost_empty[1]=1 (count 1). Pop[1] → pop_ok=4'b0010 same cycle; next cycle data_out_1=6'b01_0101, valid_out=4'b0010.
- Push 5 words with dest 2, DEPTH=4 → full[2]=1 after 4th, almost_full[2]=1 after 3rd. 5th dropped, error=1; error stays 1 through later pops.
- FIFO 3 full, push (dest 3) and pop[3] in the same cycle → count stays 4, error stays 0. Popped data is the oldest word; the new word is read last after 4 more pops.
- Pop all four on empty bank → pop_ok=0, valid_out=0; with FIFOs 0 and 2 holding 1 word each, pop=4'hF → pop_ok=4'b0101.
- Fill/drain FIFO 0 ten times with incrementing data → output order matches input across pointer wrap.
- Assert rst asynchronously mid-burst (between edges) → outputs reach reset values immediately. With PAUSE_EN, pause follows almost_full with 1-cycle delay.
